// File: rtl/milano_pkg.sv
// Shared definitions for the milano fetch front end: fetch FSM states and boot address.
package milano_pkg;

    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: DEPTH x WIDTH circular FIFO with synchronous flush and occupancy count.
// Latency: a push is visible at head_dat the cycle after it is written; the head is read combinationally.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; flush overrides push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one-outstanding request FSM to instruction RAM feeding a small buffer; INSTR_FETCH_BUS_ERR_EN adds a per-entry bus error.
// Latency: request one cycle after a free slot is seen; response data reaches the outputs the cycle after rvalid.
// Backpressure: no request is issued unless buffered plus in-flight entries fit; id_ready_i low holds the head.
module instr_fetch
    import milano_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
`ifdef INSTR_FETCH_BUS_ERR_EN
    input  logic        instr_err_i,
    output logic        instr_fetch_err_o,
`endif
    input  logic        id_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef INSTR_FETCH_BUS_ERR_EN
    localparam int DAT_W = 65;
`else
    localparam int DAT_W = 64;
`endif

    fetch_state_e     state;
    logic [31:0]      fetch_pc;
    logic             discard;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   count_nxt;
    logic             slot_free;
    logic [31:0]      pc_eff;
    logic [DAT_W-1:0] push_dat;
    logic [DAT_W-1:0] head_dat;

    // A branch wins over everything: it flushes, blocks the push of a returning
    // old-path word and suppresses the pop.
    assign pop    = !fifo_empty && id_ready_i && !branch_i;
    assign push   = (state == FETCH_WAIT) && instr_rvalid_i && !discard && !branch_i;
    assign pc_eff = branch_i ? {branch_target_i[31:2], 2'b00} : fetch_pc;

    always_comb begin
        count_nxt = '0;
        if (!branch_i) begin
            count_nxt = {1'b0, fifo_count} + (CNT_W + 1)'(push) - (CNT_W + 1)'(pop);
        end
    end

    assign slot_free = fetch_en_i && (count_nxt < (CNT_W + 1)'(FIFO_DEPTH));

`ifdef INSTR_FETCH_BUS_ERR_EN
    assign push_dat          = {instr_err_i, instr_rdata_i, instr_addr_o};
    assign instr_fetch_err_o = !fifo_empty && head_dat[64];
`else
    assign push_dat = {instr_rdata_i, instr_addr_o};
`endif
    assign instr_rdata_o = head_dat[63:32];
    assign instr_pc_o    = head_dat[31:0];
    assign instr_valid_o = !fifo_empty;

    // fetch_pc is the address of the next request to issue; instr_addr_o keeps
    // the address of the current/last request and tags the returning data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= FETCH_IDLE;
            instr_req_o  <= 1'b0;
            instr_addr_o <= BOOT_ADDR;
            fetch_pc     <= BOOT_ADDR;
            discard      <= 1'b0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    fetch_pc <= pc_eff;
                    if (slot_free) begin
                        state        <= FETCH_REQ;
                        instr_req_o  <= 1'b1;
                        instr_addr_o <= pc_eff;
                    end
                end
                FETCH_REQ: begin
                    if (branch_i) begin
                        discard <= 1'b1;
                    end
                    if (instr_gnt_i) begin
                        state       <= FETCH_WAIT;
                        instr_req_o <= 1'b0;
                        fetch_pc    <= (branch_i || discard) ? pc_eff : fetch_pc + 32'd4;
                    end else begin
                        fetch_pc <= pc_eff;
                    end
                end
                FETCH_WAIT: begin
                    fetch_pc <= pc_eff;
                    if (instr_rvalid_i) begin
                        discard <= 1'b0;
                        if (slot_free) begin
                            state        <= FETCH_REQ;
                            instr_req_o  <= 1'b1;
                            instr_addr_o <= pc_eff;
                        end else begin
                            state <= FETCH_IDLE;
                        end
                    end else if (branch_i) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state       <= FETCH_IDLE;
                    instr_req_o <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DAT_W)
    ) u_fetch_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (branch_i),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: RAM responder fills a scoreboard, consumer pops and compares.
`timescale 1ns/1ps
module tb_instr_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
        logic        err;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_en_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        id_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;
`ifdef INSTR_FETCH_BUS_ERR_EN
    logic        instr_err_i;
    logic        instr_fetch_err_o;
`endif

    exp_t        sb[$];
    logic [31:0] gnt_log[$];
    logic [31:0] gnt_addr;
    logic        gnt_hold;
    logic        resp_err;
    int          drop_cnt;
    int          resp_num;
    int          err_resp;
    int          checks = 0;
    int          errors = 0;

    instr_fetch #(
        .BOOT_ADDR  (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .fetch_en_i        (fetch_en_i),
        .branch_i          (branch_i),
        .branch_target_i   (branch_target_i),
        .instr_req_o       (instr_req_o),
        .instr_addr_o      (instr_addr_o),
        .instr_gnt_i       (instr_gnt_i),
        .instr_rvalid_i    (instr_rvalid_i),
        .instr_rdata_i     (instr_rdata_i),
`ifdef INSTR_FETCH_BUS_ERR_EN
        .instr_err_i       (instr_err_i),
        .instr_fetch_err_o (instr_fetch_err_o),
`endif
        .id_ready_i        (id_ready_i),
        .instr_valid_o     (instr_valid_o),
        .instr_rdata_o     (instr_rdata_o),
        .instr_pc_o        (instr_pc_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1111};
    endfunction

    // RAM model: grants in the cycle the request is seen, answers one cycle later.
    initial begin
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        gnt_addr       = '0;
        resp_err       = 1'b0;
`ifdef INSTR_FETCH_BUS_ERR_EN
        instr_err_i    = 1'b0;
`endif
        forever begin
            @(posedge clk_i);
            #1;
            instr_rvalid_i = 1'b0;
            resp_err       = 1'b0;
            if (!rst_i && instr_gnt_i) begin
                resp_num++;
                resp_err       = (resp_num == err_resp);
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem_word(gnt_addr);
                if (drop_cnt > 0) begin
                    drop_cnt--;
                end else begin
                    exp_t e;
                    e.pc  = gnt_addr;
                    e.dat = mem_word(gnt_addr);
                    e.err = resp_err;
                    sb.push_back(e);
                end
            end
`ifdef INSTR_FETCH_BUS_ERR_EN
            instr_err_i = resp_err;
`endif
            instr_gnt_i = 1'b0;
            if (!rst_i && instr_req_o && !gnt_hold) begin
                instr_gnt_i = 1'b1;
                gnt_addr    = instr_addr_o;
                gnt_log.push_back(instr_addr_o);
            end
        end
    end

    // Consumer: every accepted instruction must match the scoreboard head.
    initial forever begin
        @(negedge clk_i);
        #1;
        if (!rst_i) begin
`ifdef INSTR_FETCH_BUS_ERR_EN
            if (!instr_valid_o) check_eq("err_no_valid", instr_fetch_err_o, 0);
            else if (sb.size() > 0) check_eq("err_head", instr_fetch_err_o, sb[0].err);
`endif
            if (instr_valid_o && id_ready_i && !branch_i) begin
                check_eq("pop_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("pop_pc", instr_pc_o, e.pc);
                    check_eq("pop_dat", instr_rdata_o, e.dat);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        fetch_en_i = 1'b0;
        id_ready_i = 1'b1;
        for (int i = 0; i < 200 && quiet < 4; i++) begin
            @(negedge clk_i);
            if (!instr_valid_o && !instr_req_o && !instr_gnt_i && !instr_rvalid_i) quiet++;
            else quiet = 0;
        end
        check_eq({tag, "_settle"}, quiet, 4);
        check_eq({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    task automatic do_branch(input logic [31:0] tgt, input logic rdy);
        if (instr_req_o) drop_cnt = 1;
        sb.delete();
        branch_i        = 1'b1;
        branch_target_i = tgt;
        id_ready_i      = rdy;
        @(negedge clk_i);
        branch_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i           = 1'b1;
        fetch_en_i      = 1'b0;
        branch_i        = 1'b0;
        branch_target_i = '0;
        id_ready_i      = 1'b0;
        gnt_hold        = 1'b0;
        drop_cnt        = 0;
        resp_num        = 0;
        err_resp        = 0;
        cyc(3);
        check_eq("rst_req", instr_req_o, 0);
        check_eq("rst_addr", instr_addr_o, 32'h0);
        check_eq("rst_valid", instr_valid_o, 0);
        check_eq("rst_rdata", instr_rdata_o, 0);
        check_eq("rst_pc", instr_pc_o, 0);
        rst_i = 1'b0;

        // Sequential fetch from the boot address.
        id_ready_i = 1'b1;
        fetch_en_i = 1'b1;
        for (int i = 0; i < 50 && gnt_log.size() < 3; i++) @(negedge clk_i);
        fetch_en_i = 1'b0;
        check_eq("seq_grants", gnt_log.size() >= 3, 1);
        if (gnt_log.size() >= 3) begin
            check_eq("seq_addr0", gnt_log[0], 32'h0);
            check_eq("seq_addr1", gnt_log[1], 32'h4);
            check_eq("seq_addr2", gnt_log[2], 32'h8);
        end
        wait_idle("seq");

        // Decoder stalled: buffer fills to two entries, then one pop frees one slot.
        gnt_log.delete();
        id_ready_i = 1'b0;
        fetch_en_i = 1'b1;
        cyc(15);
        check_eq("full_req_low", instr_req_o, 0);
        check_eq("full_grants", gnt_log.size(), 2);
        check_eq("full_valid", instr_valid_o, 1);
        id_ready_i = 1'b1;
        @(negedge clk_i);
        id_ready_i = 1'b0;
        cyc(10);
        check_eq("one_pop_grants", gnt_log.size(), 3);
        check_eq("one_pop_req_low", instr_req_o, 0);
        wait_idle("full");

        // Branch while a request waits for grant: request held, its data discarded.
        gnt_log.delete();
        gnt_hold = 1'b1;
        do_branch(32'h10, 1'b1);
        fetch_en_i = 1'b1;
        for (int i = 0; i < 20 && !instr_req_o; i++) @(negedge clk_i);
        check_eq("pend_addr", instr_addr_o, 32'h10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_eq("pend_req_held", instr_req_o, 1);
            check_eq("pend_addr_held", instr_addr_o, 32'h10);
        end
        do_branch(32'h103, 1'b1);
        check_eq("pend_req_after_br", instr_req_o, 1);
        check_eq("pend_addr_after_br", instr_addr_o, 32'h10);
        gnt_hold = 1'b0;
        for (int i = 0; i < 30 && gnt_log.size() < 2; i++) @(negedge clk_i);
        check_eq("redir_grants", gnt_log.size() >= 2, 1);
        if (gnt_log.size() >= 2) begin
            check_eq("redir_old_addr", gnt_log[0], 32'h10);
            check_eq("redir_new_addr", gnt_log[1], 32'h100);
        end
        for (int i = 0; i < 30 && !instr_valid_o; i++) @(negedge clk_i);
        check_eq("redir_first_pc", instr_pc_o, 32'h100);
        wait_idle("redir");

        // Branch coinciding with a pop and a push.
        gnt_log.delete();
        id_ready_i = 1'b0;
        fetch_en_i = 1'b1;
        for (int i = 0; i < 30 && !(instr_valid_o && instr_rvalid_i); i++) @(negedge clk_i);
        check_eq("flush_setup", instr_valid_o && instr_rvalid_i, 1);
        do_branch(32'h200, 1'b1);
        check_eq("flush_valid_low", instr_valid_o, 0);
        for (int i = 0; i < 30 && !instr_valid_o; i++) @(negedge clk_i);
        check_eq("flush_first_pc", instr_pc_o, 32'h200);
        wait_idle("flush");

        // PC wrap at the top of the address space.
        gnt_log.delete();
        do_branch(32'hFFFF_FFF8, 1'b1);
        fetch_en_i = 1'b1;
        for (int i = 0; i < 50 && gnt_log.size() < 3; i++) @(negedge clk_i);
        fetch_en_i = 1'b0;
        check_eq("wrap_grants", gnt_log.size() >= 3, 1);
        if (gnt_log.size() >= 3) begin
            check_eq("wrap_addr0", gnt_log[0], 32'hFFFF_FFF8);
            check_eq("wrap_addr1", gnt_log[1], 32'hFFFF_FFFC);
            check_eq("wrap_addr2", gnt_log[2], 32'h0);
        end
        wait_idle("wrap");

        // Second response flagged with a bus error.
        gnt_log.delete();
        resp_num   = 0;
        err_resp   = 2;
        id_ready_i = 1'b0;
        fetch_en_i = 1'b1;
        for (int i = 0; i < 30 && gnt_log.size() < 2; i++) @(negedge clk_i);
        cyc(6);
        fetch_en_i = 1'b0;
        check_eq("err_fill_valid", instr_valid_o, 1);
`ifdef INSTR_FETCH_BUS_ERR_EN
        check_eq("err_first_head", instr_fetch_err_o, 0);
`endif
        id_ready_i = 1'b1;
        @(negedge clk_i);
        id_ready_i = 1'b0;
        check_eq("err_second_valid", instr_valid_o, 1);
`ifdef INSTR_FETCH_BUS_ERR_EN
        check_eq("err_second_head", instr_fetch_err_o, 1);
`endif
        wait_idle("err");
        err_resp = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: clk_i, rst_i.
REQ-002 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, PC loaded on reset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, the number of fetched-instruction buffer entries.
REQ-004 SHALL have ports, one per line:
 clk_i  in  1  clock
 rst_i  in  1  async reset, active-high
 fetch_en_i  in  1  allow new instruction-memory requests
 branch_i  in  1  redirect pulse from EX
 branch_target_i  in  32  redirect PC; bits [1:0] ignored
 instr_req_o  out  1  instruction-RAM request
 instr_addr_o  out  32  word-aligned request address
 instr_gnt_i  in  1  request accepted
 instr_rvalid_i  in  1  read data valid
 instr_rdata_i  in  32  read data from RAM
 id_ready_i  in  1  IF-ID register can accept
 instr_valid_o  out  1  instruction available to IF-ID
 instr_rdata_o  out  32  instruction word to the IF-ID register, feeding the decoder
 instr_pc_o  out  32  PC of instr_rdata_o

Function
REQ-005 SHALL contain a fetch FSM with states IDLE (no request), REQ (instr_req_o=1, awaiting grant) and WAIT (granted, awaiting rvalid).
REQ-006 SHALL move IDLE->REQ when fetch_en_i=1 and (FIFO count + outstanding) < FIFO_DEPTH.
REQ-007 SHALL move REQ->WAIT on instr_gnt_i=1, and hold instr_addr_o stable while instr_req_o=1 and instr_gnt_i=0.
REQ-008 SHALL move WAIT->REQ on instr_rvalid_i when REQ-006 still holds, otherwise WAIT->IDLE; at most one request outstanding.
REQ-009 SHALL increment the fetch PC by 4 on each grant, wrapping 32'hFFFF_FFFC->32'h0.
REQ-010 SHALL push {rdata, pc} into the FIFO on instr_rvalid_i unless the response is marked discard; data becomes visible on outputs the following cycle (no bypass).
REQ-011 SHALL drive instr_valid_o = FIFO not empty, with instr_rdata_o/instr_pc_o from the head; pop when instr_valid_o && id_ready_i.
REQ-012 SHALL permit push and pop in the same cycle, leaving the count unchanged.
REQ-013 on branch_i: SHALL flush the FIFO (instr_valid_o=0 next cycle) and set the fetch PC to {branch_target_i[31:2],2'b00}.
REQ-014 on branch_i with a request outstanding (WAIT) or pending ungranted (REQ): SHALL keep the pending request unchanged until granted and mark its response discard; the first request at the target SHALL issue after that response returns.
REQ-015 SHALL give branch_i priority over a simultaneous pop or push.
REQ-016 with fetch_en_i=0: SHALL issue no new request from IDLE; an outstanding request completes and its data is buffered normally.

Reset
REQ-017 SHALL, on rst_i asserted, asynchronously force: FSM=IDLE, instr_req_o=0, instr_addr_o=BOOT_ADDR, fetch PC=BOOT_ADDR, FIFO empty, instr_valid_o=0, instr_rdata_o=0, instr_pc_o=0, discard flag=0.
REQ-018 SHALL, on reset assertion mid-transaction, abandon the transaction; the RAM side is reset together with this block.

Configuration
REQ-019 SHALL, with INSTR_FETCH_BUS_ERR_EN defined, add input instr_err_i (sampled with instr_rvalid_i), store it per FIFO entry and output it as instr_fetch_err_o alongside instr_valid_o.
REQ-020 SHALL, with INSTR_FETCH_BUS_ERR_EN undefined, omit both ports and the per-entry error bit.

Structure
REQ-021 SHALL take the FSM state enum and the BOOT_ADDR default from shared package milano_pkg.
REQ-022 SHALL implement the buffer as sub-module fetch_fifo (parameterised depth and width, push/pop/flush, count output).

Verification
REQ-023 Reset released, fetch_en_i=1, gnt same cycle, rvalid next cycle, id_ready_i=1 -> addresses 0x0, 0x4, 0x8 in order; instr_pc_o follows 0x0, 0x4, 0x8 with matching data.
REQ-024 id_ready_i=0 -> after 2 entries, instr_req_o stays 0; id_ready_i=1 for one cycle -> exactly one new request is issued.
REQ-025 Ungranted request to 0x10 held 3 cycles, then branch_i with target 0x103 -> addr 0x10 is held until gnt and its data is discarded; next request is at 0x100; instr_pc_o first shows 0x100.
REQ-026 Branch in the same cycle as a pop and a push -> FIFO is empty and instr_valid_o=0 next cycle.
REQ-027 PC at 0xFFFF_FFFC -> next request address is 0x0.
REQ-028 INSTR_FETCH_BUS_ERR_EN defined, instr_err_i=1 on the 2nd response -> instr_fetch_err_o=1 only while that entry is at the head.
